// File: rtl/spi_master_if.sv
// Host-side handshake and SPI pin bundle for spi_master.
// The master modport is the spi_master view; the slave modport is the environment view.
interface spi_master_if;
  logic        start;
  logic [31:0] d;
  logic [31:0] q;
  logic        done;
  logic        busy;
  logic        sck;
  logic        sdo;
  logic        sdi;
  logic        cs_n;

  modport master (
    input  start, d, sdi,
    output q, done, busy, sck, sdo, cs_n
  );

  modport slave (
    output start, d, sdi,
    input  q, done, busy, sck, sdo, cs_n
  );
endinterface

// File: rtl/spi_master.sv
// 32-bit SPI master: sck idles low, sdi sampled on sck rise, sdo changes on sck fall, MSB first.
// All outputs are registered; sck is CLK_DIV clk cycles per half-period.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.master bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     tx_sr_q, tx_sr_d;
  logic [31:0]     rx_sr_q, rx_sr_d;
  logic [31:0]     q_q, q_d;
  logic [4:0]      bitcnt_q, bitcnt_d;
  logic [DW-1:0]   divcnt_q, divcnt_d;
  logic            sck_q, sck_d;
  logic            cs_n_q, cs_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Next-state and registered-output logic for the transfer sequencer.
  always_comb begin
    state_d  = state_q;
    tx_sr_d  = tx_sr_q;
    rx_sr_d  = rx_sr_q;
    q_d      = q_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;
    sck_d    = sck_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      // The done cycle also accepts a new request, giving back-to-back
      // transfers a start-to-start spacing of 64*CLK_DIV+1 cycles.
      IDLE, DONE: begin
        if (bus.start) begin
          tx_sr_d  = bus.d;
          bitcnt_d = 5'd0;
          divcnt_d = '0;
          sck_d    = 1'b0;
          cs_n_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = LOW;
        end else begin
          sck_d    = 1'b0;
          cs_n_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      LOW: begin
        if (divcnt_q == DIV_MAX) begin
          sck_d    = 1'b1;
          rx_sr_d  = {rx_sr_q[30:0], bus.sdi};
          divcnt_d = '0;
          state_d  = HIGH;
        end else begin
          divcnt_d = divcnt_q + DW'(1'b1);
        end
      end
      HIGH: begin
        if (divcnt_q == DIV_MAX) begin
          sck_d    = 1'b0;
          divcnt_d = '0;
          if (bitcnt_q == 5'd31) begin
            q_d     = rx_sr_q;
            done_d  = 1'b1;
            cs_n_d  = 1'b1;
            state_d = DONE;
          end else begin
            tx_sr_d  = {tx_sr_q[30:0], 1'b0};
            bitcnt_d = bitcnt_q + 5'd1;
            state_d  = LOW;
          end
        end else begin
          divcnt_d = divcnt_q + DW'(1'b1);
        end
      end
      default: begin
        sck_d   = 1'b0;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tx_sr_q  <= 32'd0;
      rx_sr_q  <= 32'd0;
      q_q      <= 32'd0;
      bitcnt_q <= 5'd0;
      divcnt_q <= '0;
      sck_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_sr_q  <= tx_sr_d;
      rx_sr_q  <= rx_sr_d;
      q_q      <= q_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
      sck_q    <= sck_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.sdo  = tx_sr_q[31];
  assign bus.sck  = sck_q;
  assign bus.cs_n = cs_n_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.q    = q_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed steps plus random transfers against
// a behavioural SPI slave and loopback, with timing measured in clk cycles from acceptance.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset4;
  logic reset1;
  spi_master_if if4();
  spi_master_if if1();

  spi_master #(.CLK_DIV(4)) dut4 (.clk(clk), .reset(reset4), .bus(if4.master));
  spi_master #(.CLK_DIV(1)) dut1 (.clk(clk), .reset(reset1), .bus(if1.master));

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural slave: presents slv_d MSB first, advancing one bit after each sck fall,
  // and collects the master's sdo on each sck rise.
  logic        loop4 = 1'b1;
  logic [31:0] slv_d = 32'd0;
  logic [31:0] slv_rx = 32'd0;
  logic        sck_prev = 1'b0;
  int          slv_idx = 0;
  int          rise4 = 0;
  int          done_cnt4 = 0;
  logic        slv_bit;

  assign slv_bit = (slv_idx < 32) ? slv_d[31 - slv_idx] : 1'b0;
  assign if4.sdi = loop4 ? if4.sdo : slv_bit;
  assign if1.sdi = if1.sdo;

  always @(posedge clk) begin
    if (if4.cs_n !== 1'b0) slv_idx <= 0;
    else if (sck_prev === 1'b1 && if4.sck === 1'b0) slv_idx <= slv_idx + 1;
    if (if4.cs_n === 1'b0 && sck_prev === 1'b0 && if4.sck === 1'b1) begin
      slv_rx <= {slv_rx[30:0], if4.sdo};
      rise4  <= rise4 + 1;
    end
    if (if4.done === 1'b1) done_cnt4 <= done_cnt4 + 1;
    sck_prev <= if4.sck;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle4(input string tag);
    check({tag, "_sck"},  {31'd0, if4.sck},  32'd0);
    check({tag, "_sdo"},  {31'd0, if4.sdo},  32'd0);
    check({tag, "_cs_n"}, {31'd0, if4.cs_n}, 32'd1);
    check({tag, "_busy"}, {31'd0, if4.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, if4.done}, 32'd0);
    check({tag, "_q"},    if4.q,             32'd0);
  endtask

  // disturb: 0 none, 1 start pulse + d change at bit 10, 2 one-cycle reset at bit 10
  task automatic run4(input logic [31:0] dv, input int disturb,
                      output int done_at, output int busy_off, output int first_rise,
                      output int ndone, output int nrise, output logic [31:0] qv);
    int r0;
    int d0;
    r0 = rise4;
    d0 = done_cnt4;
    done_at = -1;
    busy_off = -1;
    first_rise = -1;
    if4.start = 1'b1;
    if4.d = dv;
    @(posedge clk); #1;
    if4.start = 1'b0;
    check("accept_busy", {31'd0, if4.busy}, 32'd1);
    check("accept_cs_n", {31'd0, if4.cs_n}, 32'd0);
    check("accept_sdo",  {31'd0, if4.sdo},  {31'd0, dv[31]});
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (first_rise < 0 && if4.sck === 1'b1) first_rise = n;
      if (done_at < 0 && if4.done === 1'b1) done_at = n;
      if (busy_off < 0 && done_at >= 0 && if4.busy === 1'b0) busy_off = n;
      if (disturb == 1 && n == 80) begin
        if4.start = 1'b1;
        if4.d = 32'hFFFF_FFFF;
      end
      if (disturb == 1 && n == 81) if4.start = 1'b0;
      if (disturb == 2 && n == 80) reset4 = 1'b1;
      if (disturb == 2 && n == 81) begin
        check_idle4("midreset");
        reset4 = 1'b0;
      end
      if (busy_off >= 0) break;
    end
    @(posedge clk); #1;
    ndone = done_cnt4 - d0;
    nrise = rise4 - r0;
    qv = if4.q;
  endtask

  initial begin
    int done_at, busy_off, first_rise, ndone, nrise;
    logic [31:0] qv, dv, sv;
    int done_at_q[$];
    int cs_hi_cnt, cs_hi_at;
    logic cs_hi_sck;

    // Reset held 3 cycles with start asserted
    reset4 = 1'b1;
    reset1 = 1'b1;
    if4.start = 1'b1;
    if4.d = 32'hFFFF_FFFF;
    if1.start = 1'b1;
    if1.d = 32'h5A3C_96E1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle4("reset");
    end
    reset4 = 1'b0;
    if4.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    check("post_reset_busy", {31'd0, if4.busy}, 32'd0);
    check("post_reset_cs_n", {31'd0, if4.cs_n}, 32'd1);
    check("post_reset_rises", rise4, 32'd0);

    // Loopback at CLK_DIV=4
    loop4 = 1'b1;
    run4(32'hA5A5_0F0F, 0, done_at, busy_off, first_rise, ndone, nrise, qv);
    check("lb_done_at", done_at, 32'd256);
    check("lb_busy_off", busy_off, 32'd257);
    check("lb_first_rise", first_rise, 32'd4);
    check("lb_ndone", ndone, 32'd1);
    check("lb_nrise", nrise, 32'd32);
    check("lb_q", qv, 32'hA5A5_0F0F);
    check("lb_sdo_bits", slv_rx, 32'hA5A5_0F0F);

    // Against the behavioural slave
    loop4 = 1'b0;
    slv_d = 32'h1234_5678;
    run4(32'hDEAD_BEEF, 0, done_at, busy_off, first_rise, ndone, nrise, qv);
    check("slv_q", qv, 32'h1234_5678);
    check("slv_xcoor", {16'd0, slv_rx[31:16]}, 32'h0000_DEAD);
    check("slv_ycoor", {16'd0, slv_rx[15:0]},  32'h0000_BEEF);
    check("slv_nrise", nrise, 32'd32);

    // Start pulse and d change at bit 10 are ignored
    loop4 = 1'b1;
    run4(32'h0000_0001, 1, done_at, busy_off, first_rise, ndone, nrise, qv);
    check("ign_q", qv, 32'h0000_0001);
    check("ign_ndone", ndone, 32'd1);
    check("ign_done_at", done_at, 32'd256);
    @(posedge clk); #1;
    check("ign_idle_busy", {31'd0, if4.busy}, 32'd0);

    // One-cycle reset at bit 10 aborts without done, then a fresh transfer
    run4(32'h0000_0001, 2, done_at, busy_off, first_rise, ndone, nrise, qv);
    check("abort_ndone", ndone, 32'd0);
    check("abort_done_at", done_at, 32'hFFFF_FFFF);
    check("abort_q", qv, 32'd0);
    run4(32'h8000_0000, 0, done_at, busy_off, first_rise, ndone, nrise, qv);
    check("after_abort_q", qv, 32'h8000_0000);
    check("after_abort_done_at", done_at, 32'd256);

    // Random transfers, loopback or slave
    for (int t = 0; t < 5; t++) begin
      dv = $urandom;
      sv = $urandom;
      loop4 = 1'($urandom_range(0, 1));
      slv_d = sv;
      run4(dv, 0, done_at, busy_off, first_rise, ndone, nrise, qv);
      check("rnd_q", qv, loop4 ? dv : sv);
      check("rnd_sdo_bits", slv_rx, dv);
      check("rnd_done_at", done_at, 32'd256);
      check("rnd_busy_off", busy_off, 32'd257);
      check("rnd_ndone", ndone, 32'd1);
    end

    // CLK_DIV=1 with start held high: back-to-back transfers
    reset1 = 1'b0;
    @(posedge clk); #1;
    check("b2b_accept_busy", {31'd0, if1.busy}, 32'd1);
    check("b2b_accept_cs_n", {31'd0, if1.cs_n}, 32'd0);
    cs_hi_cnt = 0;
    cs_hi_at = -1;
    cs_hi_sck = 1'bx;
    for (int n = 1; n <= 140; n++) begin
      @(posedge clk); #1;
      if (if1.done === 1'b1) done_at_q.push_back(n);
      if (n <= 128 && if1.cs_n !== 1'b0) begin
        cs_hi_cnt++;
        cs_hi_at = n;
        cs_hi_sck = if1.sck;
      end
    end
    check("b2b_ndone", done_at_q.size(), 32'd2);
    if (done_at_q.size() >= 2) begin
      check("b2b_done0", done_at_q[0], 32'd64);
      check("b2b_done1", done_at_q[1], 32'd129);
    end
    check("b2b_cs_hi_cnt", cs_hi_cnt, 32'd1);
    check("b2b_cs_hi_at", cs_hi_at, 32'd64);
    check("b2b_cs_hi_sck", {31'd0, cs_hi_sck}, 32'd0);
    check("b2b_q", if1.q, 32'h5A3C_96E1);
    if1.start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
